writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
- Consumer end of the MEM/WB pipeline register. Takes the registered writeback-stage controls and data, and forms the writeback result.
- Commits that result into the 32-entry architectural register file.
- Serves the two decode-stage read ports, with same-cycle write-to-read bypass, so that decode never needs a split-cycle (negedge) write.
- Sits between the MEM/WB register outputs and the ID stage. ResultW is also exported for the forwarding unit.

Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register address width; depth is 2**ADDR_W
- LINK_REG, 31, destination register forced by jal
- BYPASS_EN, 1, 1 = write-to-read bypass on read ports; 0 = reads return array contents only

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Rst_n  in  1  asynchronous active-low reset
- MemtoRegW  in  1  select MemReadDataW as result
- RegWriteW  in  1  writeback enable
- MemReadDataW  in  DATA_W  load data from memory stage
- ALUResultW  in  DATA_W  ALU result
- WriteRegW  in  ADDR_W  destination register
- PCPlus4W  in  DATA_W  return address for jal
- jalW  in  1  jal in writeback: write PCPlus4W to LINK_REG
- A1  in  ADDR_W  decode read address 1 (rs)
- A2  in  ADDR_W  decode read address 2 (rt)
- RD1  out  DATA_W  read data 1
- RD2  out  DATA_W  read data 2
- ResultW  out  DATA_W  selected writeback value, for forwarding
- WriteRegFinalW  out  ADDR_W  effective destination after jal override
- WrEnFinalW  out  1  a write will actually commit this cycle

Behaviour:
- Reset (stated exactly as decided): one clock; reset is asynchronous and active-low.
  - Rst_n low clears all array entries to 0 immediately, without waiting for Clk.
  - While Rst_n is low: no write commits; WrEnFinalW = 0; RD1 = RD2 = 0.
  - ResultW and WriteRegFinalW remain combinational functions of the inputs.
  - Deassertion takes effect at the next rising edge; no writes are lost other than those presented while Rst_n was low.
- Result select (combinational): ResultW = jalW ? PCPlus4W : (MemtoRegW ? MemReadDataW : ALUResultW). jalW has priority over MemtoRegW.
- Destination: WriteRegFinalW = jalW ? LINK_REG : WriteRegW.
- Write enable: WrEnFinalW = Rst_n & RegWriteW & (WriteRegFinalW != 0).
  - Writes to register 0 are discarded.
  - jalW with RegWriteW = 0 commits nothing.
- Commit: on the rising edge of Clk with WrEnFinalW = 1, the array entry at WriteRegFinalW takes ResultW. Latency from WB inputs to array update is 1 edge.
- Reads are combinational:
  - Address 0 always returns 0, regardless of bypass.
  - Else, if BYPASS_EN = 1, WrEnFinalW = 1 and A == WriteRegFinalW: return ResultW (the value being written this cycle).
  - Otherwise return the array entry.
- A1 == A2 == write address: both ports bypass identically.
- Back-to-back writes to the same register: the last edge wins; no merging.
- Widths: all data is DATA_W exactly; no sign/zero extension inside the block.
- X-safety: no X on RD1/RD2 after reset for any address.

Test Plan:
- Assert Rst_n = 0 mid-cycle after writing reg 5 = 0xDEADBEEF -> reg 5 reads 0 before the next Clk edge; RD1 = 0 while reset is held.
- RegWriteW = 1, WriteRegW = 8, ALUResultW = 0x12345678, MemtoRegW = 0, A1 = 8 in the same cycle -> RD1 = 0x12345678 before the edge (bypass); after the edge with RegWriteW = 0, RD1 still 0x12345678.
- MemtoRegW = 1, MemReadDataW = 0xCAFEF00D, ALUResultW = 0x1, WriteRegW = 9 -> reg 9 = 0xCAFEF00D; ResultW = 0xCAFEF00D.
- jalW = 1, RegWriteW = 1, PCPlus4W = 0x00400024, WriteRegW = 3 -> WriteRegFinalW = 31; reg 31 = 0x00400024; reg 3 unchanged.
- RegWriteW = 1, WriteRegW = 0, ALUResultW = 0xFFFFFFFF, A1 = A2 = 0 -> WrEnFinalW = 0; RD1 = RD2 = 0 before and after the edge.
- BYPASS_EN = 0: write reg 4 = 0xA5A5A5A5 with A2 = 4 -> RD2 shows the old value before the edge and 0xA5A5A5A5 after it.

Source files
------------

// File: rtl/writeback_regfile_if.sv
// Writeback/register-file bus: MEM/WB register outputs and decode read
// addresses into the block, and read data plus the final writeback
// controls back out to decode and the forwarding unit.
interface writeback_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // writeback-stage controls and data (from MEM/WB register)
  logic              MemtoRegW;
  logic              RegWriteW;
  logic [DATA_W-1:0] MemReadDataW;
  logic [DATA_W-1:0] ALUResultW;
  logic [ADDR_W-1:0] WriteRegW;
  logic [DATA_W-1:0] PCPlus4W;
  logic              jalW;
  // decode-stage read ports
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  // final writeback values, exported for forwarding
  logic [DATA_W-1:0] ResultW;
  logic [ADDR_W-1:0] WriteRegFinalW;
  logic              WrEnFinalW;

  // pipeline/decode side
  modport master (
    output MemtoRegW, RegWriteW, MemReadDataW, ALUResultW, WriteRegW,
           PCPlus4W, jalW, A1, A2,
    input  RD1, RD2, ResultW, WriteRegFinalW, WrEnFinalW
  );

  // register-file side
  modport slave (
    input  MemtoRegW, RegWriteW, MemReadDataW, ALUResultW, WriteRegW,
           PCPlus4W, jalW, A1, A2,
    output RD1, RD2, ResultW, WriteRegFinalW, WrEnFinalW
  );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage plus architectural register file.
// Forms ResultW from the MEM/WB controls, commits it on the rising edge,
// and serves two combinational decode read ports with optional
// write-to-read bypass so decode sees the value being written this cycle.
// Storage is flops (not block RAM) because reset must clear every entry
// asynchronously.
module writeback_regfile #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int LINK_REG  = 31,
  parameter bit BYPASS_EN = 1'b1
) (
  input logic                Clk,
  input logic                Rst_n,
  writeback_regfile_if.slave wb
);
  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int NUM_RD   = 2;

  logic [DATA_W-1:0] result;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  logic [ADDR_W-1:0] rd_addr [NUM_RD];
  logic [DATA_W-1:0] rd_data [NUM_RD];

  // Result select: jal return address beats memory data beats ALU result.
  assign result  = wb.jalW      ? wb.PCPlus4W     :
                   wb.MemtoRegW ? wb.MemReadDataW : wb.ALUResultW;

  // jal always links through LINK_REG regardless of the decoded destination.
  assign wr_addr = wb.jalW ? ADDR_W'(LINK_REG) : wb.WriteRegW;

  // Register 0 is hardwired to zero, so writes to it are dropped here; reset
  // also blocks commit so nothing presented during reset is kept.
  assign wr_en   = Rst_n & wb.RegWriteW & (wr_addr != '0);

  assign wb.ResultW        = result;
  assign wb.WriteRegFinalW = wr_addr;
  assign wb.WrEnFinalW     = wr_en;

  // Next-state of the array: only the committed entry changes.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_addr] = result;
    end
  end

  // Array state: asynchronously cleared, updated once per edge (last edge wins).
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_addr[0] = wb.A1;
  assign rd_addr[1] = wb.A2;

  // Identical read ports: zero register and reset first, then bypass, then array.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic is_zero;
    logic bypass_hit;

    assign is_zero    = (rd_addr[gi] == '0) | ~Rst_n;
    assign bypass_hit = BYPASS_EN & wr_en & (rd_addr[gi] == wr_addr);

    assign rd_data[gi] = is_zero    ? '0     :
                         bypass_hit ? result : regs_q[rd_addr[gi]];
  end

  assign wb.RD1 = rd_data[0];
  assign wb.RD2 = rd_data[1];
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: one bypassing instance and one
// non-bypassing instance driven with the same stimulus.
module tb_writeback_regfile;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  writeback_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
  writeback_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

  writeback_regfile #(
    .DATA_W(32), .ADDR_W(5), .LINK_REG(31), .BYPASS_EN(1'b1)
  ) dut_b (
    .Clk(clk), .Rst_n(rst_n), .wb(bus_b)
  );

  writeback_regfile #(
    .DATA_W(32), .ADDR_W(5), .LINK_REG(31), .BYPASS_EN(1'b0)
  ) dut_n (
    .Clk(clk), .Rst_n(rst_n), .wb(bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s got=%08h", tag, got);
    end
  endtask

  // Apply one writeback + read request to both instances.
  task automatic drive(input logic rw, input logic m2r, input logic jal,
                       input logic [4:0] wr, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc,
                       input logic [4:0] a1, input logic [4:0] a2);
    bus_b.RegWriteW = rw;  bus_n.RegWriteW = rw;
    bus_b.MemtoRegW = m2r; bus_n.MemtoRegW = m2r;
    bus_b.jalW = jal;      bus_n.jalW = jal;
    bus_b.WriteRegW = wr;  bus_n.WriteRegW = wr;
    bus_b.ALUResultW = alu;   bus_n.ALUResultW = alu;
    bus_b.MemReadDataW = mem; bus_n.MemReadDataW = mem;
    bus_b.PCPlus4W = pc;   bus_n.PCPlus4W = pc;
    bus_b.A1 = a1;         bus_n.A1 = a1;
    bus_b.A2 = a2;         bus_n.A2 = a2;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 5'd7, 32'h1111_2222, 32'h0, 32'h0, 5'd7, 5'd7);

    // Reset held: write attempt is blocked, reads are zero, ResultW still live.
    @(negedge clk); #1;
    check_eq("rst_wren", {31'd0, bus_b.WrEnFinalW}, 32'd0);
    check_eq("rst_rd1", bus_b.RD1, 32'd0);
    check_eq("rst_rd2", bus_b.RD2, 32'd0);
    check_eq("rst_result", bus_b.ResultW, 32'h1111_2222);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd0);
    #1;
    check_eq("rst_nowrite_r7", bus_b.RD1, 32'd0);

    // ALU write to r8 with same-cycle read: bypass vs. no bypass.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 5'd8, 32'h1234_5678, 32'h0, 32'h0, 5'd8, 5'd8);
    #1;
    check_eq("byp_rd1_r8", bus_b.RD1, 32'h1234_5678);
    check_eq("byp_rd2_r8", bus_b.RD2, 32'h1234_5678);
    check_eq("byp_wren", {31'd0, bus_b.WrEnFinalW}, 32'd1);
    check_eq("nobyp_rd1_r8_pre", bus_n.RD1, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 5'd8, 32'h0, 32'h0, 32'h0, 5'd8, 5'd0);
    #1;
    check_eq("commit_rd1_r8", bus_b.RD1, 32'h1234_5678);
    check_eq("nobyp_rd1_r8_post", bus_n.RD1, 32'h1234_5678);

    // Load result to r9.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_0001, 32'hCAFE_F00D, 32'h0, 5'd0, 5'd9);
    #1;
    check_eq("load_result", bus_b.ResultW, 32'hCAFE_F00D);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd9);
    #1;
    check_eq("load_rd2_r9", bus_b.RD2, 32'hCAFE_F00D);

    // jal (with MemtoRegW also set) links to r31, r3 untouched.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h5555_5555, 32'h6666_6666, 32'h0040_0024,
          5'd31, 5'd3);
    #1;
    check_eq("jal_dest", {27'd0, bus_b.WriteRegFinalW}, 32'd31);
    check_eq("jal_result", bus_b.ResultW, 32'h0040_0024);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd31, 5'd3);
    #1;
    check_eq("jal_rd1_r31", bus_b.RD1, 32'h0040_0024);
    check_eq("jal_rd2_r3", bus_b.RD2, 32'd0);

    // jal without RegWriteW commits nothing.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 5'd3, 32'h0, 32'h0, 32'h0000_0BAD, 5'd31, 5'd0);
    #1;
    check_eq("jal_norw_wren", {31'd0, bus_b.WrEnFinalW}, 32'd0);
    check_eq("jal_norw_rd1", bus_b.RD1, 32'h0040_0024);

    // Write to r0 is discarded.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0);
    #1;
    check_eq("r0_wren", {31'd0, bus_b.WrEnFinalW}, 32'd0);
    check_eq("r0_rd1_pre", bus_b.RD1, 32'd0);
    check_eq("r0_rd2_pre", bus_b.RD2, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    #1;
    check_eq("r0_rd1_post", bus_b.RD1, 32'd0);
    check_eq("r0_rd2_post", bus_b.RD2, 32'd0);

    // Non-bypass instance: old value before the edge, new value after.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 5'd4, 32'h1111_1111, 32'h0, 32'h0, 5'd0, 5'd4);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 5'd4, 32'hA5A5_A5A5, 32'h0, 32'h0, 5'd0, 5'd4);
    #1;
    check_eq("nobyp_rd2_old", bus_n.RD2, 32'h1111_1111);
    check_eq("byp_rd2_new", bus_b.RD2, 32'hA5A5_A5A5);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd4);
    #1;
    check_eq("nobyp_rd2_new", bus_n.RD2, 32'hA5A5_A5A5);

    // Back-to-back writes to r10: last edge wins.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 5'd10, 32'h0000_0001, 32'h0, 32'h0, 5'd10, 5'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 5'd10, 32'h0000_0002, 32'h0, 32'h0, 5'd10, 5'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd10, 5'd0);
    #1;
    check_eq("b2b_r10", bus_b.RD1, 32'h0000_0002);

    // Async reset mid-cycle clears r5 before any clock edge.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd8);
    #1;
    check_eq("pre_rst_r5", bus_b.RD1, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_r5", bus_b.RD1, 32'd0);
    check_eq("async_rst_r5_nb", bus_n.RD1, 32'd0);
    check_eq("async_rst_r8", bus_b.RD2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_r5", bus_b.RD1, 32'd0);
    check_eq("post_rst_r8", bus_b.RD2, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
